bus_tx_port: RTL and testbench



---
 rtl/bus_tx_port.sv | 99 +++++++++
 tb/tb_bus_tx_port.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bus_tx_port.sv
// bus_tx_port: queued bus transmitter with per-word hold, burst limit and request gap; `define BUS_TX_STATS_EN adds sent/preempt counters
module bus_tx_port #(
  parameter int N = 8,
  parameter int DEPTH = 4,
  parameter int HOLD = 2,
  parameter int BURST_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [N-1:0]           wr_data,
  output logic                   wr_ready,
  output logic                   req,
  input  logic                   grant,
  output logic [N-1:0]           data_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
`ifdef BUS_TX_STATS_EN
  ,
  output logic [15:0]            sent_cnt,
  output logic [7:0]             preempt_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX);
  typedef enum logic [1:0] {IDLE, REQ, DRIVE, GAP} state_t;
  state_t state, state_nx;
  logic [N-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [BW-1:0] burst_cnt, burst_nx;
  logic push, pop;
  assign wr_ready = count != FULL;
  assign push = wr_valid & wr_ready;
  assign pop = state == DRIVE && grant && hold_cnt == HOLD_LAST;
  assign req = state == REQ || state == DRIVE;
  assign busy = state != IDLE;
  assign data_out = count != '0 ? mem[rd_ptr] : '0;
  always_comb begin
    state_nx = state;
    hold_nx = hold_cnt;
    burst_nx = burst_cnt;
    unique case (state)
      IDLE: state_nx = count != '0 ? REQ : IDLE;
      REQ: if (grant) begin
        state_nx = DRIVE;
        hold_nx = '0;
        burst_nx = '0;
      end
      DRIVE: if (!grant) begin
        state_nx = REQ;
        hold_nx = '0;
      end else if (pop) begin
        hold_nx = '0;
        burst_nx = burst_cnt + 1'b1;
        state_nx = ((count == ONE && !push) || burst_cnt + 1'b1 == BURST_LAST) ? GAP : DRIVE;
      end else begin
        hold_nx = hold_cnt + 1'b1;
      end
      GAP: state_nx = (count != '0 || push) ? REQ : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      hold_cnt <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_nx;
      hold_cnt <= hold_nx;
      burst_cnt <= burst_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
`ifdef BUS_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_cnt <= '0;
      preempt_cnt <= '0;
    end else begin
      if (pop) sent_cnt <= sent_cnt + 1'b1;
      if (state == DRIVE && !grant && preempt_cnt != 8'hFF) preempt_cnt <= preempt_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_bus_tx_port.sv
// tb_bus_tx_port: directed per-cycle vectors for bus_tx_port; observed tuple is {req, busy, wr_ready, count, data_out}
module tb_bus_tx_port;
  logic clk, rst, wr_valid, grant, wr_ready, req, busy;
  logic [7:0] wr_data, data_out;
  logic [2:0] count;
  logic [13:0] obs;
  int nvec = 0, nerr = 0;
`ifdef BUS_TX_STATS_EN
  logic [15:0] sent_cnt;
  logic [7:0] preempt_cnt;
`endif

  bus_tx_port dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .req(req), .grant(grant), .data_out(data_out), .busy(busy), .count(count)
`ifdef BUS_TX_STATS_EN
    , .sent_cnt(sent_cnt), .preempt_cnt(preempt_cnt)
`endif
  );

  assign obs = {req, busy, wr_ready, count, data_out};

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [13:0] e(bit r, bit b, bit w, logic [2:0] c, logic [7:0] d);
    return {r, b, w, c, d};
  endfunction

  function automatic logic [9:0] s(bit v, bit g, logic [7:0] d);
    return {v, g, d};
  endfunction

  task automatic test_reset();
    rst = 1; wr_valid = 1; wr_data = 8'hFF; grant = 0;
    repeat (2) @(negedge clk);
    rst = 0; wr_valid = 0;
    nvec++;
    if (obs !== e(0, 0, 1, 0, 8'h00)) begin nerr++; $display("FAIL reset got=%b want=%b", obs, e(0, 0, 1, 0, 8'h00)); end
    @(negedge clk);
    nvec++;
    if (obs !== e(0, 0, 1, 0, 8'h00)) begin nerr++; $display("FAIL reset_hold got=%b want=%b", obs, e(0, 0, 1, 0, 8'h00)); end
  endtask

  task automatic test_single();
    logic [9:0] st [8];
    logic [13:0] ex [8];
    st = '{s(1,0,8'hA5), s(0,0,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0)};
    ex = '{e(0,0,1,0,8'h00), e(0,0,1,1,8'hA5), e(1,1,1,1,8'hA5), e(1,1,1,1,8'hA5),
           e(1,1,1,1,8'hA5), e(0,1,1,0,8'h00), e(0,0,1,0,8'h00), e(0,0,1,0,8'h00)};
    for (int i = 0; i < 8; i++) begin
      {wr_valid, grant, wr_data} = st[i];
      nvec++;
      if (obs !== ex[i]) begin nerr++; $display("FAIL single[%0d] got=%b want=%b", i, obs, ex[i]); end
      @(negedge clk);
    end
    grant = 0;
  endtask

  task automatic test_fill();
    logic [9:0] st [19];
    logic [13:0] ex [19];
    st = '{s(1,0,8'h11), s(1,0,8'h22), s(1,0,8'h33), s(1,0,8'h44), s(1,1,8'h55), s(1,1,8'h55),
           s(1,1,8'h55), s(1,1,8'h55), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0),
           s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0)};
    ex = '{e(0,0,1,0,8'h00), e(0,0,1,1,8'h11), e(1,1,1,2,8'h11), e(1,1,1,3,8'h11), e(1,1,0,4,8'h11),
           e(1,1,0,4,8'h11), e(1,1,0,4,8'h11), e(1,1,1,3,8'h22), e(1,1,0,4,8'h22), e(1,1,1,3,8'h33),
           e(1,1,1,3,8'h33), e(1,1,1,2,8'h44), e(1,1,1,2,8'h44), e(0,1,1,1,8'h55), e(1,1,1,1,8'h55),
           e(1,1,1,1,8'h55), e(1,1,1,1,8'h55), e(0,1,1,0,8'h00), e(0,0,1,0,8'h00)};
    for (int i = 0; i < 19; i++) begin
      {wr_valid, grant, wr_data} = st[i];
      nvec++;
      if (obs !== ex[i]) begin nerr++; $display("FAIL fill[%0d] got=%b want=%b", i, obs, ex[i]); end
      @(negedge clk);
    end
    grant = 0;
  endtask

  task automatic test_preempt();
    logic [9:0] st [10];
    logic [13:0] ex [10];
    rst = 1;
    @(negedge clk);
    rst = 0;
    st = '{s(1,0,8'h5A), s(0,0,0), s(0,1,0), s(0,1,0), s(0,0,0), s(0,1,0), s(0,1,0), s(0,1,0),
           s(0,0,0), s(0,0,0)};
    ex = '{e(0,0,1,0,8'h00), e(0,0,1,1,8'h5A), e(1,1,1,1,8'h5A), e(1,1,1,1,8'h5A), e(1,1,1,1,8'h5A),
           e(1,1,1,1,8'h5A), e(1,1,1,1,8'h5A), e(1,1,1,1,8'h5A), e(0,1,1,0,8'h00), e(0,0,1,0,8'h00)};
    for (int i = 0; i < 10; i++) begin
      {wr_valid, grant, wr_data} = st[i];
      nvec++;
      if (obs !== ex[i]) begin nerr++; $display("FAIL preempt[%0d] got=%b want=%b", i, obs, ex[i]); end
      @(negedge clk);
    end
`ifdef BUS_TX_STATS_EN
    nvec++;
    if ({sent_cnt, preempt_cnt} !== {16'd1, 8'd1}) begin
      nerr++; $display("FAIL stats sent=%0d preempt=%0d want sent=1 preempt=1", sent_cnt, preempt_cnt);
    end
`endif
  endtask

  task automatic test_burst();
    logic [9:0] st [17];
    logic [13:0] ex [17];
    st = '{s(1,1,8'hC1), s(1,1,8'hC2), s(1,1,8'hC3), s(1,1,8'hC4), s(1,1,8'hC5), s(1,1,8'hC5),
           s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0), s(0,1,0),
           s(0,1,0), s(0,1,0), s(0,0,0)};
    ex = '{e(0,0,1,0,8'h00), e(0,0,1,1,8'hC1), e(1,1,1,2,8'hC1), e(1,1,1,3,8'hC1), e(1,1,0,4,8'hC1),
           e(1,1,1,3,8'hC2), e(1,1,0,4,8'hC2), e(1,1,1,3,8'hC3), e(1,1,1,3,8'hC3), e(1,1,1,2,8'hC4),
           e(1,1,1,2,8'hC4), e(0,1,1,1,8'hC5), e(1,1,1,1,8'hC5), e(1,1,1,1,8'hC5), e(1,1,1,1,8'hC5),
           e(0,1,1,0,8'h00), e(0,0,1,0,8'h00)};
    for (int i = 0; i < 17; i++) begin
      {wr_valid, grant, wr_data} = st[i];
      nvec++;
      if (obs !== ex[i]) begin nerr++; $display("FAIL burst[%0d] got=%b want=%b", i, obs, ex[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] st [11];
    logic [13:0] ex [11];
    st = '{s(1,0,8'h61), s(1,0,8'h62), s(0,1,0), s(0,1,0), s(1,1,8'h77), s(0,1,0), s(0,1,0),
           s(0,1,0), s(0,1,0), s(0,0,0), s(0,0,0)};
    ex = '{e(0,0,1,0,8'h00), e(0,0,1,1,8'h61), e(1,1,1,2,8'h61), e(1,1,1,2,8'h61), e(1,1,1,2,8'h61),
           e(1,1,1,2,8'h62), e(1,1,1,2,8'h62), e(1,1,1,1,8'h77), e(1,1,1,1,8'h77), e(0,1,1,0,8'h00),
           e(0,0,1,0,8'h00)};
    for (int i = 0; i < 11; i++) begin
      {wr_valid, grant, wr_data} = st[i];
      nvec++;
      if (obs !== ex[i]) begin nerr++; $display("FAIL simul[%0d] got=%b want=%b", i, obs, ex[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_drive();
    logic [9:0] st [5];
    logic [13:0] ex [5];
    st = '{s(1,0,8'h99), s(1,0,8'h9A), s(0,1,0), s(0,1,0), s(0,1,0)};
    ex = '{e(0,0,1,0,8'h00), e(0,0,1,1,8'h99), e(1,1,1,2,8'h99), e(1,1,1,2,8'h99), e(1,1,1,2,8'h99)};
    for (int i = 0; i < 5; i++) begin
      {wr_valid, grant, wr_data} = st[i];
      nvec++;
      if (obs !== ex[i]) begin nerr++; $display("FAIL mid_rst[%0d] got=%b want=%b", i, obs, ex[i]); end
      if (i < 4) @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0; grant = 0;
    nvec++;
    if (obs !== e(0, 0, 1, 0, 8'h00)) begin nerr++; $display("FAIL mid_rst_after got=%b want=%b", obs, e(0, 0, 1, 0, 8'h00)); end
`ifdef BUS_TX_STATS_EN
    nvec++;
    if ({sent_cnt, preempt_cnt} !== 24'd0) begin
      nerr++; $display("FAIL stats_rst sent=%0d preempt=%0d want 0 0", sent_cnt, preempt_cnt);
    end
`endif
    @(negedge clk);
    nvec++;
    if (obs !== e(0, 0, 1, 0, 8'h00)) begin nerr++; $display("FAIL mid_rst_idle got=%b want=%b", obs, e(0, 0, 1, 0, 8'h00)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_preempt();
    test_burst();
    test_simultaneous();
    test_reset_mid_drive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
